adc_capture: RTL
================

# adc_capture

Parametrised ADC capture front end that replaces the fixed-rate single-register capture stage. The sample rate is set by a programmable clock-enable divider on the system clock, so no dedicated PLL output is needed. Each sample can be averaged over 1 to 8 points and optionally converted from offset-binary to two's complement. Results are buffered in a small FIFO with a ready/valid output toward the modulator/DSP chain.

## Interface
- DATA_W, 10, ADC sample width
- DIV_W, 16, divider counter width
- FIFO_DEPTH, 16, output FIFO entries (power of two, ≥2)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  capture enable
- div  in  DIV_W  sample period minus one, in clk cycles (0 = every cycle)
- avg_log2  in  2  averaging: 0→1, 1→2, 2→4, 3→8 samples (value 3 is the maximum)
- fmt  in  1  0 = pass unsigned, 1 = invert MSB (offset-binary → two's complement)
- data_in  in  DATA_W  raw ADC bus
- dout  out  DATA_W  FIFO head word
- dout_valid  out  1  head word valid
- dout_ready  in  1  consumer accepts head word
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: a result was dropped because the FIFO was full
- clr_ovf  in  1  clears overflow

## Operation
- Input register in_q loads data_in on every edge, unconditionally.
- Divider: when en=1, cnt counts 0..div_l then wraps. tick_q is a registered pulse that is high for one cycle when cnt wraps. div_l loads div at each wrap and whenever en=0, so a new div applies from the next period.
- en=0: cnt=0, tick_q=0, accumulator and sample count cleared. On en rising, avg_l latches avg_log2 and fmt_l latches fmt. FIFO contents are retained and can still be drained.
- Accumulator: width DATA_W+3, unsigned. On tick_q, acc += in_q and scnt++. When scnt reaches 2^avg_l−1 on a tick, result = (acc+in_q) >> avg_l, truncated, not rounded. acc and scnt then clear.
- Format: if fmt_l=1, result[DATA_W-1] is inverted. This is applied after averaging.
- Push: the result is registered into res_q with push_q=1 for one cycle.
  - If the FIFO is full and no pop occurs in that cycle, the word is dropped and overflow is set.
  - A push and pop on a full FIFO in the same cycle are both accepted.
- Overflow: if a set event and clr_ovf occur in the same cycle, the set wins.
- FIFO is first-word-fall-through. A pop occurs when dout_valid && dout_ready. dout holds while dout_valid=1 and dout_ready=0.
- Push and pop on an empty FIFO in the same cycle: the pop is ignored because dout_valid=0, and the push is stored.

## Timing
- Reset values: dout=0, dout_valid=0, level=0, overflow=0. All internal registers reset to 0.
- Sample point: the word captured is the value of data_in at edge T−1, where T is the edge at which tick_q=1.
- Latency with avg_l=0 and an empty FIFO:
  - push_q is high in the cycle after T.
  - dout_valid is high after edge T+2.
- Averaging: dout_valid rises 2 edges after the tick that completes each 2^avg_l group.
- Throughput:
  - Results arrive at most once every (div_l+1)·2^avg_l cycles.
  - With div=0 and avg=0, one word per cycle is sustained if dout_ready=1.
- Reset mid-operation: the FIFO, accumulator, counters and overflow clear immediately. The next result needs a full new group.

## Structure
- Package adc_capture_pkg:
  - ACC_W function (DATA_W+3)
  - fmt constants FMT_UNSIGNED and FMT_TWOS
  - level width function
- Sub-module sync_fifo_fwft, parametrised by width and depth:
  - ports push/din/full, pop/dout/valid, level
  - single clock, async active-low reset
- Top level holds the input register, divider, accumulator, format stage and overflow logic.

## Test plan
- Reset mid-stream: assert rst_n=0 with 5 words in the FIFO → dout_valid=0, level=0, overflow=0 within the same cycle. The first word after release appears only after a full divider period.
- div=4, avg=0, fmt=0, ramp on data_in → one word every 5 cycles. Each dout equals data_in at the edge before its tick. dout_valid rises 2 edges after each tick.
- div=0, avg=2, data_in cycling 1,2,3,4 → dout=2 (10>>2, truncated), one result every 4 cycles.
- fmt=1, avg=0, data_in=10'h200 and 10'h000 → dout=10'h000 and 10'h200.
- dout_ready=0, FIFO_DEPTH=16, div=0 → level saturates at 16 and overflow=1. With clr_ovf pulsed at the same cycle as a drop, overflow stays 1. With dout_ready=1 and full, a simultaneous push and pop leave level=16 and overflow unchanged.
- Change div 9→2 mid-period with en=1 → the current period completes at 10 cycles, and subsequent periods are 3 cycles. en=0 freezes output words, the FIFO drains normally, and no new pushes occur.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and sizing helpers for the ADC capture front end.
package adc_capture_pkg;

  typedef enum logic {
    FMT_UNSIGNED = 1'b0,
    FMT_TWOS     = 1'b1
  } fmt_e;

  function automatic int acc_w(input int data_w);
    return data_w + 3;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/adc_capture_fifo.sv
// First-word-fall-through FIFO: memory plus a registered head word.
module sync_fifo_fwft
  import adc_capture_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            din,
  output logic                        full,
  input  logic                        pop,
  output logic [WIDTH-1:0]            dout,
  output logic                        valid,
  output logic [lvl_w(DEPTH)-1:0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0] mem_cnt_q, mem_cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             pop_ok, push_ok, take;

  assign level = mem_cnt_q + LVL_W'(valid_q);
  assign full  = (level == LVL_W'(DEPTH));
  assign dout  = dout_q;
  assign valid = valid_q;

  always_comb begin
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    mem_cnt_d = mem_cnt_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    take      = 1'b0;
    pop_ok    = pop && valid_q;
    // a pop frees the head register, so a full FIFO can still take a word
    push_ok   = push && (!full || pop_ok);

    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PTR_W'(1);
    end

    if (!valid_q || pop_ok) begin
      if (mem_cnt_q != '0) begin
        dout_d  = mem_q[rd_q];
        valid_d = 1'b1;
        rd_d    = rd_q + PTR_W'(1);
        take    = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end

    mem_cnt_d = mem_cnt_q + LVL_W'(push_ok) - LVL_W'(take);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      mem_cnt_q <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      mem_cnt_q <= mem_cnt_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: rtl/adc_capture.sv
// ADC capture: input register, clock-enable divider, averaging, format
// conversion and overflow tracking in front of an FWFT output FIFO.
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int DATA_W     = 10,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [DIV_W-1:0]                div,
  input  logic [1:0]                      avg_log2,
  input  logic                            fmt,
  input  logic [DATA_W-1:0]               data_in,
  output logic [DATA_W-1:0]               dout,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic [lvl_w(FIFO_DEPTH)-1:0]    level,
  output logic                            overflow,
  input  logic                            clr_ovf
);

  localparam int ACC_W = acc_w(DATA_W);

  logic [DATA_W-1:0] in_q, in_d;
  logic              en_q, en_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, div_l_q, div_l_d;
  logic              tick_q, tick_d;
  logic [1:0]        avg_l_q, avg_l_d;
  fmt_e              fmt_l_q, fmt_l_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [2:0]        scnt_q, scnt_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              push_q, push_d;
  logic              ovf_q, ovf_d;

  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] avg_res;
  logic [2:0]        last_scnt;
  logic              fifo_full, pop;

  assign pop      = dout_valid && dout_ready;
  assign overflow = ovf_q;

  always_comb begin
    in_d    = data_in;
    en_d    = en;
    cnt_d   = cnt_q;
    div_l_d = div_l_q;
    tick_d  = 1'b0;
    avg_l_d = avg_l_q;
    fmt_l_d = fmt_l_q;
    acc_d   = acc_q;
    scnt_d  = scnt_q;
    res_d   = res_q;
    push_d  = 1'b0;
    ovf_d   = ovf_q;

    sum       = acc_q + ACC_W'(in_q);
    avg_res   = DATA_W'(sum >> avg_l_q);
    last_scnt = 3'((4'd1 << avg_l_q) - 4'd1);

    if (en && !en_q) begin
      avg_l_d = avg_log2;
      fmt_l_d = fmt_e'(fmt);
    end

    if (!en) begin
      cnt_d   = '0;
      div_l_d = div;
      acc_d   = '0;
      scnt_d  = '0;
    end else begin
      if (cnt_q == div_l_q) begin
        cnt_d   = '0;
        tick_d  = 1'b1;
        div_l_d = div;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end

      // the last sample of a group goes straight into the result, not acc
      if (tick_q) begin
        if (scnt_q == last_scnt) begin
          res_d             = avg_res;
          res_d[DATA_W-1]   = avg_res[DATA_W-1] ^ (fmt_l_q == FMT_TWOS);
          push_d            = 1'b1;
          acc_d             = '0;
          scnt_d            = '0;
        end else begin
          acc_d  = sum;
          scnt_d = scnt_q + 3'd1;
        end
      end
    end

    if (push_q && fifo_full && !pop) ovf_d = 1'b1;
    else if (clr_ovf)                ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q    <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      div_l_q <= '0;
      tick_q  <= 1'b0;
      avg_l_q <= '0;
      fmt_l_q <= FMT_UNSIGNED;
      acc_q   <= '0;
      scnt_q  <= '0;
      res_q   <= '0;
      push_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      in_q    <= in_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      div_l_q <= div_l_d;
      tick_q  <= tick_d;
      avg_l_q <= avg_l_d;
      fmt_l_q <= fmt_l_d;
      acc_q   <= acc_d;
      scnt_q  <= scnt_d;
      res_q   <= res_d;
      push_q  <= push_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .din   (res_q),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (dout),
    .valid (dout_valid),
    .level (level)
  );

endmodule
